// File: rtl/sort_pkg.sv
// sort_pkg
// Shared definitions for the frame loader and the fsm_sort block it feeds:
// bank and presenter state encodings, default frame geometry, and the pad
// value used to fill the unused tail of a short frame.
package sort_pkg;

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_FULL  = 2'd1,
        B_SORT  = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_START = 2'd1,
        P_BUSY  = 2'd2
    } pres_state_t;

    localparam int SORT_N_DEFAULT     = 6;
    localparam int SORT_WIDTH_DEFAULT = 8;

    // All-ones of the given width. Pads sort to the tail of an ascending sort.
    function automatic logic [63:0] pad_word(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sort_frame_loader_if.sv
// sort_frame_loader_if
// Bundles the upstream sample handshake and the sorter-facing frame port.
//   in_valid/in_ready/in_data/in_last : sample stream into the loader
//   sort_start/sort_data/frame_len    : frame presented to the sorter
//   sort_done                         : sorter completion
// master = environment (upstream source + sorter), slave = the loader.
interface sort_frame_loader_if #(
    parameter int N     = 6,
    parameter int WIDTH = 8
);
    localparam int LW = $clog2(N + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             sort_start;
    logic [WIDTH-1:0] sort_data [N];
    logic [LW-1:0]    frame_len;
    logic             sort_done;

    modport master (
        output in_valid, in_data, in_last, sort_done,
        input  in_ready, sort_start, sort_data, frame_len
    );

    modport slave (
        input  in_valid, in_data, in_last, sort_done,
        output in_ready, sort_start, sort_data, frame_len
    );
endinterface

// File: rtl/sort_frame_bank.sv
// sort_frame_bank
// One ping-pong bank: N x WIDTH register file, write/pad logic, frame
// length and bank state.
//   clk, rst      : clock, synchronous active-low reset
//   wr_en         : accepted sample targets this bank
//   wr_close      : the accepted sample completes the frame
//   wr_idx        : slot of the accepted sample
//   wr_data       : sample value
//   claim         : presenter has started sorting this bank (FULL -> SORT)
//   rel           : sorter finished with this bank (SORT -> EMPTY)
//   state         : bank state
//   data          : bank contents
//   len           : number of real samples in the completed frame
module sort_frame_bank
    import sort_pkg::*;
#(
    parameter int N     = SORT_N_DEFAULT,
    parameter int WIDTH = SORT_WIDTH_DEFAULT,
    localparam int LW   = $clog2(N + 1),
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_close,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             claim,
    input  logic             rel,
    output bank_state_t      state,
    output logic [WIDTH-1:0] data [N],
    output logic [LW-1:0]    len
);

    localparam logic [WIDTH-1:0] PAD = WIDTH'(pad_word(WIDTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= B_EMPTY;
            len   <= '0;
            for (int i = 0; i < N; i++) begin
                data[i] <= '0;
            end
        end else begin
            // Closing sample and the pad fill of every slot above it land
            // on the same edge, so a FULL bank is always fully defined.
            for (int i = 0; i < N; i++) begin
                if (wr_en && (i == int'(wr_idx))) begin
                    data[i] <= wr_data;
                end else if (wr_en && wr_close && (i > int'(wr_idx))) begin
                    data[i] <= PAD;
                end
            end

            // Only an EMPTY bank is written, only a FULL bank is claimed and
            // only a SORT bank is released, so these never collide.
            if (wr_en && wr_close) begin
                len   <= LW'(wr_idx) + LW'(1);
                state <= B_FULL;
            end else if (claim) begin
                state <= B_SORT;
            end else if (rel) begin
                state <= B_EMPTY;
            end
        end
    end

endmodule

// File: rtl/sort_frame_loader.sv
// sort_frame_loader
// Collects WIDTH-bit samples into N-entry frames using two ping-pong banks
// and presents each completed frame to the sorter, overlapping the fill of
// one bank with the sort of the other.
//   clk, rst : clock, synchronous active-low reset
//   bus      : sort_frame_loader_if.slave (sample stream in, frame out)
//
// Presenter FSM
//   state   | meaning
//   P_IDLE  | waiting for bank pres_sel to become FULL
//   P_START | sort_start high for this one cycle, frame on sort_data
//   P_BUSY  | sorter running; wait for sort_done, then release the bank
module sort_frame_loader
    import sort_pkg::*;
#(
    parameter int N     = SORT_N_DEFAULT,
    parameter int WIDTH = SORT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    sort_frame_loader_if.slave  bus
);

    localparam int LW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic             fill_sel;
    logic [IW-1:0]    wr_idx;
    logic             pres_sel;
    pres_state_t      pres_state;
    logic             sort_start_q;

    bank_state_t      st_a, st_b;
    bank_state_t      fill_state, pres_bank_state;
    logic [WIDTH-1:0] data_a [N];
    logic [WIDTH-1:0] data_b [N];
    logic [LW-1:0]    len_a, len_b;

    logic             in_ready_int;
    logic             accept;
    logic             close;
    logic             claim, rel;

    assign fill_state      = fill_sel ? st_b : st_a;
    assign pres_bank_state = pres_sel ? st_b : st_a;

    // Registered bank state only: a bank released this cycle is seen as
    // EMPTY next cycle, never combinationally from sort_done.
    assign in_ready_int = rst && (fill_state == B_EMPTY);
    assign bus.in_ready = in_ready_int;

    assign accept = bus.in_valid && in_ready_int;
    assign close  = accept && (bus.in_last || (wr_idx == IW'(N - 1)));

    assign claim = (pres_state == P_START);
    assign rel   = (pres_state == P_BUSY) && bus.sort_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_sel <= 1'b0;
            wr_idx   <= '0;
        end else if (accept) begin
            if (close) begin
                wr_idx   <= '0;
                fill_sel <= ~fill_sel;
            end else begin
                wr_idx <= wr_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pres_state   <= P_IDLE;
            pres_sel     <= 1'b0;
            sort_start_q <= 1'b0;
        end else begin
            sort_start_q <= 1'b0;
            case (pres_state)
                P_IDLE: begin
                    if (pres_bank_state == B_FULL) begin
                        pres_state   <= P_START;
                        sort_start_q <= 1'b1;
                    end
                end
                P_START: begin
                    pres_state <= P_BUSY;
                end
                P_BUSY: begin
                    if (bus.sort_done) begin
                        pres_sel   <= ~pres_sel;
                        pres_state <= P_IDLE;
                    end
                end
                default: begin
                    pres_state <= P_IDLE;
                end
            endcase
        end
    end

    sort_frame_bank #(.N(N), .WIDTH(WIDTH)) u_bank_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && !fill_sel),
        .wr_close (close),
        .wr_idx   (wr_idx),
        .wr_data  (bus.in_data),
        .claim    (claim && !pres_sel),
        .rel      (rel && !pres_sel),
        .state    (st_a),
        .data     (data_a),
        .len      (len_a)
    );

    sort_frame_bank #(.N(N), .WIDTH(WIDTH)) u_bank_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && fill_sel),
        .wr_close (close),
        .wr_idx   (wr_idx),
        .wr_data  (bus.in_data),
        .claim    (claim && pres_sel),
        .rel      (rel && pres_sel),
        .state    (st_b),
        .data     (data_b),
        .len      (len_b)
    );

    assign bus.sort_start = sort_start_q;
    assign bus.frame_len  = pres_sel ? len_b : len_a;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.sort_data[i] = pres_sel ? data_b[i] : data_a[i];
        end
    end

endmodule
